// File: rtl/aer_receiver.sv
// AER receiver: synchronizes 4-phase req/ack address events into clk and queues them on a valid/ready stream.
// Optional AER_TIMESTAMP_EN adds a free-running TS_W counter captured per event and presented on evt_ts.
module aer_receiver #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned TS_W        = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          aer_req,
  input  logic [ADDR_W-1:0]             aer_addr,
  output logic                          aer_ack,
  output logic                          evt_valid,
  output logic [ADDR_W-1:0]             evt_addr,
  input  logic                          evt_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef AER_TIMESTAMP_EN
  ,
  output logic [TS_W-1:0]               evt_ts
`endif
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  // Elaboration-time parameter legality
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("aer_receiver: SYNC_STAGES must be 2..4");
  end
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("aer_receiver: FIFO_DEPTH must be a power of two in 2..16");
  end
  if (TS_W < 1) begin : g_bad_ts
    $error("aer_receiver: TS_W must be at least 1");
  end

  typedef enum logic [1:0] {
    RESYNC = 2'd0,
    IDLE   = 2'd1,
    ACK    = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] prime_q;
  logic                  req_s;
  logic                  sync_ok;
  logic                  push_c;
  logic                  pop_c;
  logic                  full_c;
  logic [CW-1:0]         count_d;
  logic [AW-1:0]         wr_ptr_q;
  logic [AW-1:0]         rd_ptr_q;
  logic [AW-1:0]         rd_ptr_d;
  logic [ADDR_W-1:0]     head_addr_d;
  logic [ADDR_W-1:0]     mem_addr [FIFO_DEPTH];

  assign req_s   = sync_q[SYNC_STAGES-1];
  // The chain holds reset zeros, not the real req level, until it has filled once.
  assign sync_ok = prime_q[SYNC_STAGES-1];
  assign full_c  = (fifo_count == CW'(FIFO_DEPTH));
  assign pop_c   = evt_valid & evt_ready;

  // req synchronizer plus fill tracker
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      prime_q <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], aer_req};
      prime_q <= {prime_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // Handshake FSM: next state and push decision
  always_comb begin
    state_d = state_q;
    push_c  = 1'b0;
    case (state_q)
      RESYNC: begin
        if (sync_ok && !req_s) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (req_s && !full_c) begin
          push_c  = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        if (!req_s) begin
          state_d = IDLE;
        end
      end
      default: state_d = RESYNC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RESYNC;
      aer_ack <= 1'b0;
    end else begin
      state_q <= state_d;
      aer_ack <= (state_d == ACK);
    end
  end

  // FIFO bookkeeping and next head entry
  always_comb begin
    count_d  = fifo_count + CW'(push_c) - CW'(pop_c);
    rd_ptr_d = pop_c ? AW'(rd_ptr_q + AW'(1)) : rd_ptr_q;
    // Only when the queue drains to empty can the new write land on the head slot.
    if (push_c && (wr_ptr_q == rd_ptr_d)) begin
      head_addr_d = aer_addr;
    end else begin
      head_addr_d = mem_addr[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_addr[wr_ptr_q] <= aer_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_count <= '0;
      evt_valid  <= 1'b0;
      evt_addr   <= '0;
    end else begin
      if (push_c) begin
        wr_ptr_q <= AW'(wr_ptr_q + AW'(1));
      end
      rd_ptr_q   <= rd_ptr_d;
      fifo_count <= count_d;
      evt_valid  <= (count_d != '0);
      evt_addr   <= head_addr_d;
    end
  end

`ifdef AER_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;
  logic [TS_W-1:0] head_ts_d;
  logic [TS_W-1:0] mem_ts [FIFO_DEPTH];

  always_comb begin
    if (push_c && (wr_ptr_q == rd_ptr_d)) begin
      head_ts_d = ts_q;
    end else begin
      head_ts_d = mem_ts[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_ts[wr_ptr_q] <= ts_q;
    end
  end

  // Free-running timestamp, wraps naturally at 2^TS_W
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q   <= '0;
      evt_ts <= '0;
    end else begin
      ts_q   <= TS_W'(ts_q + TS_W'(1));
      evt_ts <= head_ts_d;
    end
  end
`endif

endmodule

// File: tb/tb_aer_receiver.sv
// Self-checking bench for aer_receiver: queue model of accepted events plus directed handshake scenarios.
module tb_aer_receiver;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DEPTH  = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       aer_req = 1'b0;
  logic [7:0] aer_addr = 8'h00;
  logic       aer_ack;
  logic       evt_valid;
  logic [7:0] evt_addr;
  logic       evt_ready = 1'b0;
  logic [2:0] fifo_count;
`ifdef AER_TIMESTAMP_EN
  logic [3:0] evt_ts;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic       pop_pending = 1'b0;
  logic       ack_prev = 1'b0;
  logic       req_prev = 1'b0;
  int         ack_rises = 0;
  int         max_count = 0;

`ifdef AER_TIMESTAMP_EN
  aer_receiver #(.ADDR_W(ADDR_W), .SYNC_STAGES(2), .FIFO_DEPTH(DEPTH), .TS_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .aer_req(aer_req), .aer_addr(aer_addr), .aer_ack(aer_ack),
    .evt_valid(evt_valid), .evt_addr(evt_addr), .evt_ready(evt_ready),
    .fifo_count(fifo_count), .evt_ts(evt_ts));
`else
  aer_receiver #(.ADDR_W(ADDR_W), .SYNC_STAGES(2), .FIFO_DEPTH(DEPTH), .TS_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .aer_req(aer_req), .aer_addr(aer_addr), .aer_ack(aer_ack),
    .evt_valid(evt_valid), .evt_addr(evt_addr), .evt_ready(evt_ready),
    .fifo_count(fifo_count));
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: every acknowledged request enters the queue; every valid&ready leaves it.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      pop_pending = 1'b0;
      ack_prev    = 1'b0;
      req_prev    = aer_req;
    end else begin
      if (pop_pending && exp_q.size() > 0) void'(exp_q.pop_front());
      if (aer_req && !req_prev) ack_rises = 0;
      if (aer_ack && !ack_prev) begin
        exp_q.push_back(aer_addr);
        ack_rises++;
        check("ack_once_per_req", 32'(ack_rises), 32'd1);
      end
      check("model_count", 32'(fifo_count), 32'(exp_q.size()));
      check("model_valid", 32'(evt_valid), 32'(exp_q.size() != 0));
      if (evt_valid && exp_q.size() > 0) check("model_head", 32'(evt_addr), 32'(exp_q[0]));
      if (evt_valid && evt_ready) got_q.push_back(evt_addr);
      if (int'(fifo_count) > max_count) max_count = int'(fifo_count);
      pop_pending = evt_valid && evt_ready;
      ack_prev    = aer_ack;
      req_prev    = aer_req;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input logic val, input int budget, output int n);
    n = 0;
    while (aer_ack !== val) begin
      if (n >= budget) begin
        n_cmp++;
        n_err++;
        $display("FAIL ack_timeout: ack=%0b, required %0b within %0d cycles", aer_ack, val, budget);
        return;
      end
      tick();
      n++;
    end
  endtask

  task automatic handshake(input logic [7:0] a, output int rise_n, output int fall_n);
    aer_addr = a;
    aer_req  = 1'b1;
    wait_ack(1'b1, 100, rise_n);
    aer_req  = 1'b0;
    wait_ack(1'b0, 100, fall_n);
  endtask

  task automatic pulse_ready();
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
  endtask

  initial begin
    int r, f;
    logic flag;
    logic [7:0] drain_exp [4];
    drain_exp = '{8'h02, 8'h03, 8'h04, 8'h05};

    // Reset state
    #12;
    check("rst_ack", 32'(aer_ack), 32'd0);
    check("rst_valid", 32'(evt_valid), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_addr", 32'(evt_addr), 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (4) tick();

    // Single event latency
    aer_addr = 8'h5A;
    aer_req  = 1'b1;
    wait_ack(1'b1, 50, r);
    check("rise_latency", 32'(r), 32'd3);
    aer_req = 1'b0;
    wait_ack(1'b0, 50, f);
    check("fall_latency", 32'(f), 32'd3);
    check("single_valid", 32'(evt_valid), 32'd1);
    check("single_addr", 32'(evt_addr), 32'h5A);
    pulse_ready();
    check("single_drained_valid", 32'(evt_valid), 32'd0);
    check("single_drained_count", 32'(fifo_count), 32'd0);
    repeat (2) tick();

    // Backpressure when full
    for (int i = 1; i <= 4; i++) handshake(8'(i), r, f);
    check("bp_full_count", 32'(fifo_count), 32'd4);
    aer_addr = 8'h05;
    aer_req  = 1'b1;
    flag = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (aer_ack) flag = 1'b1;
    end
    check("bp_ack_held_low", 32'(flag), 32'd0);
    check("bp_head_first", 32'(evt_addr), 32'h01);
    pulse_ready();
    wait_ack(1'b1, 20, r);
    check("bp_push_after_pop", 32'(r), 32'd1);
    aer_req = 1'b0;
    wait_ack(1'b0, 50, f);
    for (int i = 0; i < 4; i++) begin
      check("bp_drain_valid", 32'(evt_valid), 32'd1);
      check("bp_drain_addr", 32'(evt_addr), 32'(drain_exp[i]));
      pulse_ready();
    end
    check("bp_empty", 32'(fifo_count), 32'd0);
    repeat (2) tick();

    // Streaming with pointer wrap
    got_q.delete();
    max_count = 0;
    evt_ready = 1'b1;
    for (int i = 0; i < 10; i++) handshake(8'(i), r, f);
    repeat (4) tick();
    evt_ready = 1'b0;
    check("wrap_n_events", 32'(got_q.size()), 32'd10);
    for (int i = 0; i < 10 && i < got_q.size(); i++) check("wrap_order", 32'(got_q[i]), 32'(i));
    check("wrap_max_one", 32'(max_count <= 1), 32'd1);

    // Simultaneous push and pop at count 2
    handshake(8'hA1, r, f);
    handshake(8'hA2, r, f);
    check("pp_pre_count", 32'(fifo_count), 32'd2);
    aer_addr = 8'hA3;
    aer_req  = 1'b1;
    tick();
    tick();
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    check("pp_ack", 32'(aer_ack), 32'd1);
    check("pp_count", 32'(fifo_count), 32'd2);
    check("pp_head", 32'(evt_addr), 32'hA2);
    aer_req = 1'b0;
    wait_ack(1'b0, 50, f);
    evt_ready = 1'b1;
    repeat (4) tick();
    evt_ready = 1'b0;
    check("pp_drained", 32'(fifo_count), 32'd0);

    // Reset in the middle of a handshake
    aer_addr = 8'h77;
    aer_req  = 1'b1;
    wait_ack(1'b1, 50, r);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ack", 32'(aer_ack), 32'd0);
    check("mid_rst_valid", 32'(evt_valid), 32'd0);
    check("mid_rst_count", 32'(fifo_count), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    flag = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (aer_ack || evt_valid) flag = 1'b1;
    end
    check("resync_no_capture", 32'(flag), 32'd0);
    aer_req = 1'b0;
    repeat (5) tick();
    handshake(8'h88, r, f);
    check("resync_rise_latency", 32'(r), 32'd3);
    check("resync_addr", 32'(evt_addr), 32'h88);
    check("resync_count", 32'(fifo_count), 32'd1);
    pulse_ready();
    repeat (2) tick();

`ifdef AER_TIMESTAMP_EN
    // Timestamp delta across a 4-bit wrap
    begin
      int t0;
      logic [3:0] ts0, ts1;
      t0 = cyc;
      handshake(8'h10, r, f);
      while (cyc - t0 < 20) tick();
      handshake(8'h11, r, f);
      ts0 = evt_ts;
      pulse_ready();
      ts1 = evt_ts;
      check("ts_delta", 32'(4'(ts1 - ts0)), 32'd4);
      pulse_ready();
      repeat (2) tick();
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #300000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
